// File: rtl/arm7_pkg.sv
// rtl/arm7_pkg.sv - shared arm7 core constants
package arm7_pkg;
    localparam int REG_IDX_W = 4;
    localparam int WORD_W    = 32;
    localparam logic [REG_IDX_W-1:0] PC_REG  = 4'd15;
    localparam logic [WORD_W-1:0]    PC_STEP = 32'd4;
endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write scoreboard with registered all_busy
module reg_scoreboard #(
    parameter int NUM_REGS = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           lock_en,
    input  logic [arm7_pkg::REG_IDX_W-1:0] lock_reg,
    input  logic                           wr_en,
    input  logic [arm7_pkg::REG_IDX_W-1:0] wr_reg,
    output logic [NUM_REGS-1:0]            pending,
    output logic                           all_busy
);
    logic [NUM_REGS-1:0] pending_next;

    // Lock is applied after the clear: a new producer issued this cycle keeps the bit set.
    always_comb begin
        pending_next = pending;
        if (wr_en)
            pending_next[wr_reg] = 1'b0;
        if (lock_en)
            pending_next[lock_reg] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            all_busy <= 1'b0;
        end else begin
            pending  <= pending_next;
            all_busy <= |pending_next;
        end
    end
endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - arm7 register file: array, three forwarding read ports, PC logic
module reg_file #(
    parameter int NUM_REGS = 16,
    parameter int WORD_W   = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           reg_read_en,
    input  logic [arm7_pkg::REG_IDX_W-1:0] reg_read_reg,
    output logic [WORD_W-1:0]              reg_read_value,
    input  logic                           op_read_en,
    input  logic [arm7_pkg::REG_IDX_W-1:0] op_a_reg,
    input  logic [arm7_pkg::REG_IDX_W-1:0] op_b_reg,
    output logic [WORD_W-1:0]              op_a_value,
    output logic [WORD_W-1:0]              op_b_value,
    input  logic                           wr_en,
    input  logic [arm7_pkg::REG_IDX_W-1:0] wr_reg,
    input  logic [WORD_W-1:0]              wr_value,
    input  logic                           pc_inc,
    input  logic                           lock_en,
    input  logic [arm7_pkg::REG_IDX_W-1:0] lock_reg,
    output logic [NUM_REGS-1:0]            pending,
    output logic                           all_busy
);
    logic [WORD_W-1:0] regs [NUM_REGS];
    logic [WORD_W-1:0] pc_plus;
    logic              wr_pc;
    logic              pc_advance;
    logic [WORD_W-1:0] fetch_data;
    logic [WORD_W-1:0] op_a_data;
    logic [WORD_W-1:0] op_b_data;

    assign pc_plus    = regs[arm7_pkg::PC_REG] + arm7_pkg::PC_STEP;
    assign wr_pc      = wr_en && (wr_reg == arm7_pkg::PC_REG);
    assign pc_advance = pc_inc && !wr_pc;

    // Value a read sees at this edge: a same-edge write first, then a pending PC step.
    function automatic logic [WORD_W-1:0] read_fwd(
        input logic [arm7_pkg::REG_IDX_W-1:0] idx,
        input logic [WORD_W-1:0]              stored
    );
        if (wr_en && (wr_reg == idx))
            return wr_value;
        else if (pc_advance && (idx == arm7_pkg::PC_REG))
            return pc_plus;
        else
            return stored;
    endfunction

    always_comb begin
        fetch_data = read_fwd(reg_read_reg, regs[reg_read_reg]);
        op_a_data  = read_fwd(op_a_reg, regs[op_a_reg]);
        op_b_data  = read_fwd(op_b_reg, regs[op_b_reg]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            reg_read_value <= '0;
            op_a_value     <= '0;
            op_b_value     <= '0;
        end else begin
            if (pc_advance)
                regs[arm7_pkg::PC_REG] <= pc_plus;
            if (wr_en)
                regs[wr_reg] <= wr_value;
            if (reg_read_en)
                reg_read_value <= fetch_data;
            if (op_read_en) begin
                op_a_value <= op_a_data;
                op_b_value <= op_b_data;
            end
        end
    end

    reg_scoreboard #(
        .NUM_REGS(NUM_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .lock_en  (lock_en),
        .lock_reg (lock_reg),
        .wr_en    (wr_en),
        .wr_reg   (wr_reg),
        .pending  (pending),
        .all_busy (all_busy)
    );
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed scoreboard bench for reg_file
module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst;
    logic        reg_read_en;
    logic [3:0]  reg_read_reg;
    logic [31:0] reg_read_value;
    logic        op_read_en;
    logic [3:0]  op_a_reg;
    logic [3:0]  op_b_reg;
    logic [31:0] op_a_value;
    logic [31:0] op_b_value;
    logic        wr_en;
    logic [3:0]  wr_reg;
    logic [31:0] wr_value;
    logic        pc_inc;
    logic        lock_en;
    logic [3:0]  lock_reg;
    logic [15:0] pending;
    logic        all_busy;

    localparam int SEL_FETCH = 0;
    localparam int SEL_OPA   = 1;
    localparam int SEL_OPB   = 2;
    localparam int SEL_PEND  = 3;
    localparam int SEL_BUSY  = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    reg_file dut (
        .clk            (clk),
        .rst            (rst),
        .reg_read_en    (reg_read_en),
        .reg_read_reg   (reg_read_reg),
        .reg_read_value (reg_read_value),
        .op_read_en     (op_read_en),
        .op_a_reg       (op_a_reg),
        .op_b_reg       (op_b_reg),
        .op_a_value     (op_a_value),
        .op_b_value     (op_b_value),
        .wr_en          (wr_en),
        .wr_reg         (wr_reg),
        .wr_value       (wr_value),
        .pc_inc         (pc_inc),
        .lock_en        (lock_en),
        .lock_reg       (lock_reg),
        .pending        (pending),
        .all_busy       (all_busy)
    );

    task automatic idle();
        rst          = 1'b0;
        reg_read_en  = 1'b0;
        reg_read_reg = 4'd0;
        op_read_en   = 1'b0;
        op_a_reg     = 4'd0;
        op_b_reg     = 4'd0;
        wr_en        = 1'b0;
        wr_reg       = 4'd0;
        wr_value     = 32'd0;
        pc_inc       = 1'b0;
        lock_en      = 1'b0;
        lock_reg     = 4'd0;
    endtask

    task automatic expect_out(input string tag, input int sel, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.sel   = sel;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                SEL_FETCH: obs = reg_read_value;
                SEL_OPA:   obs = op_a_value;
                SEL_OPB:   obs = op_b_value;
                SEL_PEND:  obs = {16'd0, pending};
                default:   obs = {31'd0, all_busy};
            endcase
            n_total++;
            assert (obs === e.value) n_pass++;
            else $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.value);
        end
    endtask

    // Apply the driven inputs at the next edge, then compare just after it.
    task automatic step();
        @(posedge clk);
        #1;
        check_all();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        expect_out("rst_fetch", SEL_FETCH, 32'd0);
        expect_out("rst_opa", SEL_OPA, 32'd0);
        expect_out("rst_opb", SEL_OPB, 32'd0);
        expect_out("rst_pending", SEL_PEND, 32'd0);
        expect_out("rst_busy", SEL_BUSY, 32'd0);
        step();

        reg_read_en = 1'b1; reg_read_reg = 4'd15;
        expect_out("read_r15_after_rst", SEL_FETCH, 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            expect_out("hold_zero", SEL_FETCH, 32'd0);
            step();
        end

        wr_en = 1'b1; wr_reg = 4'd15; wr_value = 32'h100;
        step();
        reg_read_en = 1'b1; reg_read_reg = 4'd15;
        expect_out("fetch_r15", SEL_FETCH, 32'h100);
        step();
        expect_out("fetch_hold1", SEL_FETCH, 32'h100);
        step();
        expect_out("fetch_hold2", SEL_FETCH, 32'h100);
        step();

        wr_en = 1'b1; wr_reg = 4'd4; wr_value = 32'h55;
        step();
        wr_en = 1'b1; wr_reg = 4'd3; wr_value = 32'hDEADBEEF;
        op_read_en = 1'b1; op_a_reg = 4'd3; op_b_reg = 4'd4;
        reg_read_en = 1'b1; reg_read_reg = 4'd3;
        expect_out("fwd_opa", SEL_OPA, 32'hDEADBEEF);
        expect_out("fwd_opb", SEL_OPB, 32'h55);
        expect_out("fwd_fetch", SEL_FETCH, 32'hDEADBEEF);
        step();
        op_read_en = 1'b1; op_a_reg = 4'd4; op_b_reg = 4'd3;
        expect_out("array_opa", SEL_OPA, 32'h55);
        expect_out("array_opb", SEL_OPB, 32'hDEADBEEF);
        step();

        wr_en = 1'b1; wr_reg = 4'd15; wr_value = 32'hFFFFFFFC;
        step();
        pc_inc = 1'b1;
        op_read_en = 1'b1; op_a_reg = 4'd15; op_b_reg = 4'd4;
        expect_out("pc_bypass_wrap", SEL_OPA, 32'h0);
        expect_out("pc_bypass_other", SEL_OPB, 32'h55);
        step();
        reg_read_en = 1'b1; reg_read_reg = 4'd15;
        expect_out("pc_wrap_array", SEL_FETCH, 32'h0);
        step();
        pc_inc = 1'b1;
        step();
        reg_read_en = 1'b1; reg_read_reg = 4'd15;
        expect_out("pc_inc_plain", SEL_FETCH, 32'h4);
        step();

        pc_inc = 1'b1; wr_en = 1'b1; wr_reg = 4'd15; wr_value = 32'h40;
        reg_read_en = 1'b1; reg_read_reg = 4'd15;
        expect_out("pc_wr_prio_fwd", SEL_FETCH, 32'h40);
        step();
        reg_read_en = 1'b1; reg_read_reg = 4'd15;
        expect_out("pc_wr_prio_array", SEL_FETCH, 32'h40);
        step();

        lock_en = 1'b1; lock_reg = 4'd2;
        expect_out("lock_r2_pending", SEL_PEND, 32'h0004);
        expect_out("lock_r2_busy", SEL_BUSY, 32'd1);
        step();
        lock_en = 1'b1; lock_reg = 4'd2; wr_en = 1'b1; wr_reg = 4'd2; wr_value = 32'h22;
        expect_out("lock_wins_pending", SEL_PEND, 32'h0004);
        expect_out("lock_wins_busy", SEL_BUSY, 32'd1);
        step();
        wr_en = 1'b1; wr_reg = 4'd2; wr_value = 32'h23;
        expect_out("clear_r2_pending", SEL_PEND, 32'h0);
        expect_out("clear_r2_busy", SEL_BUSY, 32'd0);
        step();
        lock_en = 1'b1; lock_reg = 4'd5;
        step();
        lock_en = 1'b1; lock_reg = 4'd5;
        expect_out("relock_r5", SEL_PEND, 32'h0020);
        step();
        wr_en = 1'b1; wr_reg = 4'd6; wr_value = 32'h66;
        expect_out("wr_nonpending", SEL_PEND, 32'h0020);
        step();
        wr_en = 1'b1; wr_reg = 4'd5; wr_value = 32'h5;
        expect_out("clear_r5_busy", SEL_BUSY, 32'd0);
        step();

        wr_en = 1'b1; wr_reg = 4'd1; wr_value = 32'd7;
        step();
        lock_en = 1'b1; lock_reg = 4'd1;
        op_read_en = 1'b1; op_a_reg = 4'd1; op_b_reg = 4'd15;
        reg_read_en = 1'b1; reg_read_reg = 4'd1;
        expect_out("pre_rst_pending", SEL_PEND, 32'h0002);
        expect_out("pre_rst_opa", SEL_OPA, 32'd7);
        expect_out("pre_rst_opb", SEL_OPB, 32'h40);
        expect_out("pre_rst_fetch", SEL_FETCH, 32'd7);
        step();
        rst = 1'b1; wr_en = 1'b1; wr_reg = 4'd1; wr_value = 32'd9;
        lock_en = 1'b1; lock_reg = 4'd3; pc_inc = 1'b1;
        expect_out("mid_rst_pending", SEL_PEND, 32'h0);
        expect_out("mid_rst_busy", SEL_BUSY, 32'd0);
        expect_out("mid_rst_fetch", SEL_FETCH, 32'd0);
        expect_out("mid_rst_opa", SEL_OPA, 32'd0);
        expect_out("mid_rst_opb", SEL_OPB, 32'd0);
        step();
        reg_read_en = 1'b1; reg_read_reg = 4'd1;
        op_read_en = 1'b1; op_a_reg = 4'd15; op_b_reg = 4'd3;
        expect_out("post_rst_r1", SEL_FETCH, 32'd0);
        expect_out("post_rst_r15", SEL_OPA, 32'd0);
        expect_out("post_rst_r3", SEL_OPB, 32'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
